// File: rtl/gf180mcu_ro_meas_pkg.sv
// Shared types and defaults for the ring-oscillator measurement sequencer.
// RO_MEAS_CTRL_AVG_EN selects the 4-pass averaging build.
package gf180mcu_ro_meas_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      MEASURE,
      REPORT
   } state_t;

   localparam int DEF_NUM_RO     = 4;
   localparam int DEF_SEL_W      = 2;
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_WIN_W      = 16;
   localparam int DEF_SETTLE_CYC = 32;

   localparam int AVG_PASSES = 4;
   localparam int AVG_SH     = $clog2(AVG_PASSES);

endpackage

// File: rtl/gf180mcu_ro_meas_sync.sv
// Two-flop synchroniser for an asynchronous ring output, plus a
// rising-edge detector built from a third flop.
module gf180mcu_ro_meas_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/gf180mcu_ro_meas_ctrl.sv
// Ring-oscillator monitor sequencer: select, settle, count, report.
// Define RO_MEAS_CTRL_AVG_EN to average four measurement windows per START.
module gf180mcu_ro_meas_ctrl
   import gf180mcu_ro_meas_pkg::*;
#(
   parameter int NUM_RO     = DEF_NUM_RO,
   parameter int SEL_W      = DEF_SEL_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int WIN_W      = DEF_WIN_W,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [SEL_W-1:0]  RO_SEL,
   input  logic [WIN_W-1:0]  WIN,
   input  logic [NUM_RO-1:0] RO_IN,
   output logic [NUM_RO-1:0] RO_EN,
   output logic              BUSY,
   output logic              DONE,
   output logic [CNT_W-1:0]  COUNT,
   output logic              OVF
);

   localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_t state;
   state_t state_nxt;

   logic [SEL_W-1:0]  sel_q;
   logic [WIN_W-1:0]  win_q;
   logic [ST_W-1:0]   st_cnt;
   logic [WIN_W-1:0]  win_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic [CNT_W-1:0]  edge_nxt;
   logic              ovf_acc;
   logic              ovf_nxt;
   logic [NUM_RO-1:0] en_q;
   logic [NUM_RO-1:0] en_dec;
   logic [CNT_W-1:0]  count_q;
   logic              ovf_q;
   logic              ro_bit;
   logic              rise;
   logic              last_pass;

`ifdef RO_MEAS_CTRL_AVG_EN
   logic [1:0]              pass;
   logic [CNT_W+AVG_SH-1:0] acc;
   logic [CNT_W+AVG_SH-1:0] acc_sum;

   assign acc_sum   = acc + {{AVG_SH{1'b0}}, edge_nxt};
   assign last_pass = (pass == 2'(AVG_PASSES - 1));
`else
   assign last_pass = 1'b1;
`endif

   // Out-of-range selects decode to no enable and a constant-low ring.
   always_comb begin
      en_dec = '0;
      for (int i = 0; i < NUM_RO; i++) begin
         if (RO_SEL == SEL_W'(i)) en_dec[i] = 1'b1;
      end
   end

   always_comb begin
      ro_bit = 1'b0;
      for (int i = 0; i < NUM_RO; i++) begin
         if (sel_q == SEL_W'(i)) ro_bit = RO_IN[i];
      end
   end

   gf180mcu_ro_meas_sync u_sync (
      .clk  (CLK),
      .rst  (RST),
      .d    (ro_bit),
      .rise (rise)
   );

   assign edge_nxt = (rise && !(&edge_cnt)) ? edge_cnt + CNT_W'(1)
                                            : edge_cnt;
   assign ovf_nxt  = ovf_acc | (rise & (&edge_cnt));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (START) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (st_cnt == '0) begin
               state_nxt = (win_q == '0) ? REPORT : MEASURE;
            end
         end
         MEASURE: begin
            if (win_cnt == '0 && last_pass) state_nxt = REPORT;
         end
         REPORT: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sel_q    <= '0;
         win_q    <= '0;
         st_cnt   <= '0;
         win_cnt  <= '0;
         edge_cnt <= '0;
         ovf_acc  <= 1'b0;
         en_q     <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
`ifdef RO_MEAS_CTRL_AVG_EN
         pass     <= '0;
         acc      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  sel_q  <= RO_SEL;
                  win_q  <= WIN;
                  en_q   <= en_dec;
                  st_cnt <= ST_W'(SETTLE_CYC - 1);
               end
            end
            SETTLE: begin
               st_cnt <= st_cnt - ST_W'(1);
               if (st_cnt == '0) begin
                  edge_cnt <= '0;
                  ovf_acc  <= 1'b0;
                  win_cnt  <= win_q - WIN_W'(1);
`ifdef RO_MEAS_CTRL_AVG_EN
                  pass     <= '0;
                  acc      <= '0;
`endif
                  if (win_q == '0) begin
                     count_q <= '0;
                     ovf_q   <= 1'b0;
                  end
               end
            end
            MEASURE: begin
               edge_cnt <= edge_nxt;
               ovf_acc  <= ovf_nxt;
               win_cnt  <= win_cnt - WIN_W'(1);
               if (win_cnt == '0) begin
`ifdef RO_MEAS_CTRL_AVG_EN
                  if (last_pass) begin
                     count_q <= acc_sum[CNT_W+AVG_SH-1:AVG_SH];
                     ovf_q   <= ovf_nxt;
                  end else begin
                     acc      <= acc_sum;
                     pass     <= pass + 2'd1;
                     edge_cnt <= '0;
                     win_cnt  <= win_q - WIN_W'(1);
                  end
`else
                  count_q <= edge_nxt;
                  ovf_q   <= ovf_nxt;
`endif
               end
            end
            REPORT: begin
               en_q <= '0;
            end
            default: en_q <= '0;
         endcase
      end
   end

   assign RO_EN = en_q;
   assign BUSY  = (state != IDLE);
   assign DONE  = (state == REPORT);
   assign COUNT = count_q;
   assign OVF   = ovf_q;

endmodule

// File: tb/tb_gf180mcu_ro_meas_ctrl.sv
// Directed bench for the RO measurement sequencer: default instance plus
// a narrow-counter, 3-ring instance for saturation and select bounds.
module tb_gf180mcu_ro_meas_ctrl;

`ifdef RO_MEAS_CTRL_AVG_EN
   localparam int P = 4;
`else
   localparam int P = 1;
`endif

   logic clk;
   logic rst;

   logic        start_a;
   logic [1:0]  sel_a;
   logic [15:0] win_a;
   logic [3:0]  ro_a;
   logic [3:0]  en_a;
   logic        busy_a;
   logic        done_a;
   logic [15:0] count_a;
   logic        ovf_a;

   logic        start_b;
   logic [1:0]  sel_b;
   logic [7:0]  win_b;
   logic [2:0]  ro_b;
   logic [2:0]  en_b;
   logic        busy_b;
   logic        done_b;
   logic [3:0]  count_b;
   logic        ovf_b;

   logic wave_a;
   logic wave_b;

   int total;
   int bad;

   gf180mcu_ro_meas_ctrl u_dut (
      .CLK    (clk),
      .RST    (rst),
      .START  (start_a),
      .RO_SEL (sel_a),
      .WIN    (win_a),
      .RO_IN  (ro_a),
      .RO_EN  (en_a),
      .BUSY   (busy_a),
      .DONE   (done_a),
      .COUNT  (count_a),
      .OVF    (ovf_a)
   );

   gf180mcu_ro_meas_ctrl #(
      .NUM_RO     (3),
      .SEL_W      (2),
      .CNT_W      (4),
      .WIN_W      (8),
      .SETTLE_CYC (4)
   ) u_sat (
      .CLK    (clk),
      .RST    (rst),
      .START  (start_b),
      .RO_SEL (sel_b),
      .WIN    (win_b),
      .RO_IN  (ro_b),
      .RO_EN  (en_b),
      .BUSY   (busy_b),
      .DONE   (done_b),
      .COUNT  (count_b),
      .OVF    (ovf_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Period 10 CLK, edges offset from the clock.
   initial begin
      wave_a = 1'b0;
      #2;
      forever #50 wave_a = ~wave_a;
   end

   // Period 2 CLK.
   initial begin
      wave_b = 1'b0;
      #2;
      forever #10 wave_b = ~wave_b;
   end

   assign ro_a = {1'b0, wave_a, wave_a, 1'b0};
   assign ro_b = {3{wave_b}};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // pulse_at<0: return at the DONE cycle; else run full span and
   // pulse a stray START at cycle pulse_at.
   task automatic run_a(input logic [1:0] sel, input logic [15:0] win,
                        input int pulse_at, input int span,
                        output int lat, output int dones,
                        output int en_bad);
      logic [3:0] exp_en;
      exp_en  = 4'b0001 << sel;
      sel_a   = sel;
      win_a   = win;
      start_a = 1'b1;
      lat     = -1;
      dones   = 0;
      en_bad  = 0;
      for (int k = 1; k <= span; k++) begin
         @(negedge clk);
         start_a = (k == pulse_at);
         if (k == pulse_at) begin
            sel_a = 2'd0;
            win_a = 16'd3;
         end
         if (busy_a && en_a !== exp_en) en_bad++;
         if (done_a) begin
            dones++;
            if (lat < 0) lat = k;
            if (pulse_at < 0) break;
         end
      end
      start_a = 1'b0;
   endtask

   task automatic run_b(input logic [1:0] sel, input logic [7:0] win,
                        input int span, output int lat,
                        output int en_bad);
      logic [2:0] exp_en;
      exp_en  = (sel < 2'd3) ? (3'b001 << sel) : 3'b000;
      sel_b   = sel;
      win_b   = win;
      start_b = 1'b1;
      lat     = -1;
      en_bad  = 0;
      for (int k = 1; k <= span; k++) begin
         @(negedge clk);
         start_b = 1'b0;
         if (busy_b && en_b !== exp_en) en_bad++;
         if (done_b) begin
            lat = k;
            break;
         end
      end
      start_b = 1'b0;
   endtask

   int lat;
   int dones;
   int en_bad;

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      start_a = 1'b0;
      sel_a   = '0;
      win_a   = '0;
      start_b = 1'b0;
      sel_b   = '0;
      win_b   = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_en", en_a, 4'b0000);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_count", count_a, 16'd0);
      chk("rst_ovf", ovf_a, 1'b0);

      run_a(2'd1, 16'd100, -1, 600, lat, dones, en_bad);
      chk("basic_lat", lat, 1 + 32 + 100 * P);
      chk("basic_count", count_a, 16'd10);
      chk("basic_ovf", ovf_a, 1'b0);
      chk("basic_en", en_bad, 0);
      @(negedge clk);
      chk("post_done", done_a, 1'b0);
      chk("post_busy", busy_a, 1'b0);
      chk("post_en", en_a, 4'b0000);
      chk("post_count", count_a, 16'd10);

      run_a(2'd1, 16'd0, -1, 100, lat, dones, en_bad);
      chk("win0_lat", lat, 33);
      chk("win0_count", count_a, 16'd0);
      @(negedge clk);

      run_a(2'd2, 16'd20, 5, 1 + 32 + 20 * P + 10, lat, dones, en_bad);
      chk("hs_dones", dones, 1);
      chk("hs_lat", lat, 1 + 32 + 20 * P);
      chk("hs_count", count_a, 16'd2);
      chk("hs_en", en_bad, 0);

      run_a(2'd1, 16'd20, -1, 200, lat, dones, en_bad);
      chk("b2b1_lat", lat, 1 + 32 + 20 * P);
      @(negedge clk);
      chk("b2b_gap_en", en_a, 4'b0000);
      chk("b2b_gap_busy", busy_a, 1'b0);
      run_a(2'd2, 16'd10, -1, 200, lat, dones, en_bad);
      chk("b2b2_lat", lat, 1 + 32 + 10 * P);
      chk("b2b2_en", en_bad, 0);
      chk("b2b2_count", count_a, 16'd1);
      @(negedge clk);

      run_a(2'd2, 16'd100, 0, 40, lat, dones, en_bad);
      chk("mid_busy", busy_a, 1'b1);
      chk("mid_en", en_a, 4'b0100);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_en", en_a, 4'b0000);
      chk("mid_rst_busy", busy_a, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_en2", en_a, 4'b0000);
      chk("mid_busy2", busy_a, 1'b0);
      chk("mid_done", done_a, 1'b0);
      chk("mid_count", count_a, 16'd0);
      chk("mid_ovf", ovf_a, 1'b0);

      run_b(2'd0, 8'd64, 400, lat, en_bad);
      chk("sat_lat", lat, 1 + 4 + 64 * P);
      chk("sat_count", count_b, 4'd15);
      chk("sat_ovf", ovf_b, 1'b1);
      chk("sat_en", en_bad, 0);
      @(negedge clk);

      run_b(2'd0, 8'd8, 100, lat, en_bad);
      chk("unsat_count", count_b, 4'd4);
      chk("unsat_ovf", ovf_b, 1'b0);
      @(negedge clk);

      run_b(2'd3, 8'd8, 100, lat, en_bad);
      chk("sel3_lat", lat, 1 + 4 + 8 * P);
      chk("sel3_en", en_bad, 0);
      chk("sel3_count", count_b, 4'd0);
      chk("sel3_ovf", ovf_b, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gf180mcu_ro_meas_ctrl.md
Name: gf180mcu_ro_meas_ctrl

Overview:
- Sequencer for an on-die inverter-chain ring-oscillator (RO) monitor bank built from 9-track inverter cells.
- Selects one of NUM_RO rings, enables it, waits a settle period, then counts its divided output over a programmable CLK window.
- Reports the edge count for process/voltage characterisation.
- Sits between the test/config register block and the analog-ish RO macro bank; exactly one ring is enabled at a time.

Parameters:
- NUM_RO, 4, number of ring oscillators in the bank (2..16)
- SEL_W, 2, width of ring select, equals clog2(NUM_RO)
- CNT_W, 16, width of edge counter and COUNT output
- WIN_W, 16, width of window-length input
- SETTLE_CYC, 32, CLK cycles between ring enable and window open (>=1)

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous reset, active-high
- START  input  1  request a measurement; sampled only in IDLE
- RO_SEL  input  SEL_W  ring index; captured on accepted START
- WIN  input  WIN_W  window length in CLK cycles; captured on accepted START
- RO_IN  input  NUM_RO  divided ring outputs, asynchronous to CLK
- RO_EN  output  NUM_RO  one-hot ring enable, all-zero when idle
- BUSY  output  1  high from accepted START until DONE inclusive
- DONE  output  1  one-cycle pulse, COUNT valid
- COUNT  output  CNT_W  last measured edge count, held until next DONE
- OVF  output  1  counter saturated in last measurement

Behaviour:
- Reset (RST=1 at CLK edge): state IDLE; RO_EN=0, BUSY=0, DONE=0, COUNT=0, OVF=0; sync flops cleared. Reset mid-measurement aborts immediately; RO_EN drops on the next edge.
- States: IDLE -> SETTLE -> MEASURE -> REPORT -> IDLE.
- IDLE: when START=1, latch RO_SEL and WIN, set RO_EN[sel]=1 and BUSY=1, load settle counter with SETTLE_CYC-1, go to SETTLE.
- RO_SEL >= NUM_RO: request is accepted, no ring is enabled, and the block reports COUNT=0 after the normal timing.
- WIN=0: skip MEASURE; REPORT with COUNT=0.
- SETTLE: decrement; at 0 clear edge counter and OVF accumulator, load window counter with WIN-1, go to MEASURE.
- Selected RO_IN bit passes through a 2-flop synchroniser plus an edge flop, which run continuously. rise = s2 & ~s3.
- MEASURE: each cycle with rise=1, edge counter +1. It saturates at all-ones and sets OVF. Window counter decrements; at 0, go to REPORT. Exactly WIN cycles are sampled.
- REPORT: one cycle. COUNT <= edge counter, OVF updated, DONE=1, RO_EN=0. BUSY stays 1 this cycle, then 0 in IDLE.
- Latency from START accepted to DONE: 1 + SETTLE_CYC + WIN cycles.
- START while BUSY is ignored, with no queueing. RO_SEL/WIN changes after acceptance have no effect.
- START asserted in the IDLE cycle right after REPORT is accepted (back-to-back allowed).
- RO_EN is registered and glitch-free; it is never multi-hot.

Optional Feature:
- Macro RO_MEAS_CTRL_AVG_EN.
- Defined: each START runs 4 consecutive SETTLE+MEASURE passes on the same ring; RO_EN stays high throughout and SETTLE runs only before the first pass. Counts accumulate in a CNT_W+2 accumulator. COUNT = accumulator >> 2. OVF = any pass saturated. Latency = 1 + SETTLE_CYC + 4*WIN. An internal 2-bit pass counter is added.
- Undefined: single pass as above; no accumulator logic present.

Decomposition:
- Package gf180mcu_ro_meas_pkg: state enum (IDLE, SETTLE, MEASURE, REPORT), default width constants, and the AVG_PASSES=4 constant.
- One sub-module, gf180mcu_ro_meas_sync: 2-flop synchroniser plus rising-edge detector, with synchronous reset.
- Mux, FSM and counters stay in the top module.

Test Plan:
- Reset: hold RST 3 cycles mid-MEASURE (RO_SEL=2) -> next cycle RO_EN=0, BUSY=0, DONE=0, COUNT=0, OVF=0.
- Basic measure: RO_SEL=1, WIN=100, RO_IN[1] square wave with period 10 CLK -> DONE exactly 133 cycles after START, COUNT=10 (±1 for phase), RO_EN=4'b0010 throughout BUSY.
- Saturation: CNT_W=4, WIN=64, RO_IN toggling period 2 -> COUNT=15, OVF=1. Next run with WIN=8 -> OVF clears.
- Boundaries: WIN=0 -> DONE at 1+SETTLE_CYC cycles, COUNT=0. RO_SEL=3 with NUM_RO=3 -> RO_EN stays 0, COUNT=0.
- Handshake: START pulsed during BUSY is ignored (single DONE); START in the cycle after DONE -> second run starts, RO_EN has no gap >1 cycle.
- AVG (macro defined): WIN=50, period 10 -> DONE at 1+32+200, COUNT=5. Window counts 5,5,6,5 -> COUNT=5.
